// File: rtl/osc_ctrl_pkg.sv
// Shared types and default constants for the oscillator tick controller.
package osc_ctrl_pkg;

  // Controller phases: waiting out the oscillator warm-up, then ticking forever.
  typedef enum logic {
    ST_STARTUP = 1'b0,
    ST_RUN     = 1'b1
  } osc_state_e;

  localparam int DEF_DIV_W          = 16;
  localparam int DEF_STARTUP_CYCLES = 1024;
  localparam int DEF_DEFAULT_DIV    = 125;
  localparam int TICK_CNT_W         = 32;

endpackage

// File: rtl/osc_tick_ctrl_rst_sync.sv
// Two-flop reset synchronizer: asserts asynchronously, releases on clk.
module rst_sync (
  input  logic clk,
  input  logic rst_i,
  output logic rst_o
);

  logic meta_q;
  logic sync_q;

  // Shift a zero in behind the released reset; any assertion forces both flops high.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= 1'b0;
      sync_q <= meta_q;
    end
  end

  assign rst_o = sync_q;

endmodule

// File: rtl/osc_tick_ctrl.sv
// Oscillator-domain sequencer: holds the downstream reset through warm-up,
// then emits a periodic tick whose divisor can be changed on period boundaries.
module osc_tick_ctrl
  import osc_ctrl_pkg::*;
#(
  parameter int DIV_W          = DEF_DIV_W,
  parameter int STARTUP_CYCLES = DEF_STARTUP_CYCLES,
  parameter int DEFAULT_DIV    = DEF_DEFAULT_DIV
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  input  logic [DIV_W-1:0]      cfg_div,
  output logic                  cfg_ready,
  output logic                  sys_rst_o,
  output logic                  ready,
  output logic                  tick,
  output logic [TICK_CNT_W-1:0] tick_cnt
);

  // Wide enough to hold STARTUP_CYCLES-1 even when STARTUP_CYCLES is 1.
  localparam int              SC_W    = $clog2(STARTUP_CYCLES + 1);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(STARTUP_CYCLES - 1);

  logic rst_s;

  osc_state_e            state_q, state_d;
  logic [SC_W-1:0]       startup_cnt_q, startup_cnt_d;
  logic [DIV_W-1:0]      cnt_q, cnt_d;
  logic [DIV_W-1:0]      cur_div_q, cur_div_d;
  logic [DIV_W-1:0]      pending_div_q, pending_div_d;
  logic                  pending_q, pending_d;
  logic                  tick_q, tick_d;
  logic [TICK_CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic                  sys_rst_q, sys_rst_d;
  logic                  ready_q, ready_d;

  logic                  cfg_xfer;
  logic [DIV_W-1:0]      period_last;

  rst_sync u_rst_sync (
    .clk   (clk),
    .rst_i (rst),
    .rst_o (rst_s)
  );

  // A zero divisor behaves as one, so the terminal count is never below zero.
  assign period_last = (cur_div_q == '0) ? '0 : cur_div_q - DIV_W'(1);
  // Only one divisor can be in flight; the slot frees on the wrap that applies it.
  assign cfg_ready   = (state_q == ST_RUN) && !pending_q;
  assign cfg_xfer    = cfg_valid && cfg_ready;

  // Next-state logic: warm-up count, period counter, and divisor hand-over.
  always_comb begin
    state_d       = state_q;
    startup_cnt_d = startup_cnt_q;
    cnt_d         = cnt_q;
    cur_div_d     = cur_div_q;
    pending_div_d = pending_div_q;
    pending_d     = pending_q;
    tick_d        = 1'b0;
    tick_cnt_d    = tick_cnt_q;
    sys_rst_d     = sys_rst_q;
    ready_d       = ready_q;
    case (state_q)
      ST_STARTUP: begin
        if (!rst_s) begin
          if (startup_cnt_q == SC_LAST) begin
            state_d   = ST_RUN;
            sys_rst_d = 1'b0;
            ready_d   = 1'b1;
          end else begin
            startup_cnt_d = startup_cnt_q + SC_W'(1);
          end
        end
      end
      ST_RUN: begin
        if (cnt_q == period_last) begin
          cnt_d      = '0;
          tick_d     = 1'b1;
          tick_cnt_d = tick_cnt_q + TICK_CNT_W'(1);
          // The period that just ended used the old divisor; the next one uses the new.
          if (pending_q) begin
            cur_div_d = pending_div_q;
            pending_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
        // A transfer can only happen with the slot empty, so it never collides
        // with the hand-over above; a transfer on a wrap waits for the next wrap.
        if (cfg_xfer) begin
          pending_div_d = cfg_div;
          pending_d     = 1'b1;
        end
      end
      default: state_d = ST_STARTUP;
    endcase
  end

  // State register; every output returns to its reset value as soon as rst rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_STARTUP;
      startup_cnt_q <= '0;
      cnt_q         <= '0;
      cur_div_q     <= DIV_W'(DEFAULT_DIV);
      pending_div_q <= '0;
      pending_q     <= 1'b0;
      tick_q        <= 1'b0;
      tick_cnt_q    <= '0;
      sys_rst_q     <= 1'b1;
      ready_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      startup_cnt_q <= startup_cnt_d;
      cnt_q         <= cnt_d;
      cur_div_q     <= cur_div_d;
      pending_div_q <= pending_div_d;
      pending_q     <= pending_d;
      tick_q        <= tick_d;
      tick_cnt_q    <= tick_cnt_d;
      sys_rst_q     <= sys_rst_d;
      ready_q       <= ready_d;
    end
  end

  assign sys_rst_o = sys_rst_q;
  assign ready     = ready_q;
  assign tick      = tick_q;
  assign tick_cnt  = tick_cnt_q;

endmodule

// File: doc/osc_tick_ctrl.md
# osc_tick_ctrl

Sequencer for the on-chip oscillator clock domain: holds the rest of the design in reset until the oscillator has run a fixed number of cycles, then generates a programmable periodic tick enable and a free-running tick count. It sits directly downstream of the oscillator wrapper, and every timer, UART baud source or CPU timebase in the design consumes `tick` instead of deriving its own divided clock. Divisor changes arrive over a valid/ready handshake and take effect only on a period boundary, so no short or long tick period is ever produced.

## Interface
- `DIV_W`, 16: width of divisor and period counter.
- `STARTUP_CYCLES`, 1024: clk cycles, counted after the reset synchronizer, before the system reset is released; ≥1.
- `DEFAULT_DIV`, 125: divisor loaded at reset (1 MHz tick at 125 MHz).
- `clk` in 1: oscillator clock; sole clock.
- `rst` in 1: asynchronous, active-high reset.
- `cfg_valid` in 1: new divisor offered.
- `cfg_div` in DIV_W: requested divisor; 0 is treated as 1.
- `cfg_ready` out 1: divisor can be accepted.
- `sys_rst_o` out 1: active-high reset for the downstream design.
- `ready` out 1: startup complete, ticks running.
- `tick` out 1: one-cycle enable pulse, once per divisor period.
- `tick_cnt` out 32: number of ticks since startup; wraps.

## Operation
- Reset synchronizer: `rst` asserts all state asynchronously. Deassertion passes through a 2-flop synchronizer, `rst_s`.
- State ST_STARTUP, entered on reset:
  - `startup_cnt` counts 0..STARTUP_CYCLES-1 while `rst_s` = 0.
  - On the terminal count, move to ST_RUN. On that edge, `sys_rst_o` goes 0 and `ready` goes 1.
- State ST_RUN: period counter `cnt` runs 0..eff_div-1, where eff_div = max(cur_div, 1).
  - When `cnt` = eff_div-1: `cnt` goes to 0, `tick` is registered high for one cycle, and `tick_cnt` increments. Otherwise `tick` = 0.
  - eff_div = 1 gives `tick` high every cycle.
- ST_RUN has no exit except `rst`.
- Config handshake:
  - `cfg_ready` = (state == ST_RUN) && !pending.
  - Transfer occurs when `cfg_valid` && `cfg_ready`. On transfer: `pending_div` ← `cfg_div`, `pending` ← 1.
  - On the next wrap edge (the edge that raises `tick`): `cur_div` ← `pending_div`, `pending` ← 0. `cnt` restarts at 0 under the new divisor.
  - If a transfer and a wrap happen on the same edge, the new value is latched as pending and is applied at the following wrap. The current period always completes with the old divisor.
  - `cfg_valid` is ignored while `cfg_ready` = 0. The requester holds `cfg_div` until the transfer.
- Width rules:
  - `cnt` and `cur_div` are DIV_W bits.
  - `tick_cnt` wraps 0xFFFFFFFF → 0 without any flag.
- Reset values:
  - Outputs: `sys_rst_o` = 1, `ready` = 0, `tick` = 0, `tick_cnt` = 0, `cfg_ready` = 0.
  - Internal: `cur_div` = DEFAULT_DIV, `pending` = 0, `cnt` = 0, `startup_cnt` = 0.
- Reset mid-operation:
  - Outputs return to reset values immediately (asynchronously).
  - Any pending divisor is discarded.
  - The full startup sequence repeats.

## Timing
- `ready` and `sys_rst_o` change on the same edge, exactly STARTUP_CYCLES + 2 rising edges after `rst` falls.
- In the first RUN cycle `cnt` = 0. The first `tick` is high in RUN cycle eff_div, i.e. eff_div edges after `ready` rises.
- Tick spacing is exactly eff_div cycles, except across a divisor change: the old period is followed directly by new periods.
- `tick_cnt` updates on the same edge that raises `tick`.
- Config latency: at most eff_div(old) cycles from transfer to application.
- All outputs are registered; no combinational path from inputs to outputs except `cfg_ready`, which depends on registers only.

## Structure
- Package `osc_ctrl_pkg` holds:
  - state enum ST_STARTUP / ST_RUN;
  - the default DIV_W, STARTUP_CYCLES and DEFAULT_DIV constants;
  - TICK_CNT_W = 32.
- Sub-module `rst_sync`: 2-flop asynchronous-assert, synchronous-deassert synchronizer, active-high in and out. It is reusable elsewhere in the design.

## Test plan
Bench parameters: STARTUP_CYCLES = 16, DEFAULT_DIV = 4.
1. Release `rst` → `sys_rst_o` falls and `ready` rises at edge 18. First `tick` 4 cycles later, then every 4 cycles. `tick_cnt` reads 1, 2, 3 …
2. `cfg_div` = 10 offered mid-period → `cfg_ready` drops after the transfer. The current 4-cycle period completes, then ticks are spaced 10 apart. `cfg_ready` returns high on the wrap edge.
3. `cfg_div` = 0, then `cfg_div` = 1 → `tick` is high every cycle in both cases. `tick_cnt` increments every cycle.
4. Transfer on the same edge as a wrap → the old divisor is used for one more full period, then the new divisor applies. No period is shorter than the old divisor.
5. `cfg_valid` held during startup → `cfg_ready` = 0 and no transfer occurs. After `ready`, the transfer happens on the first RUN cycle.
6. Assert `rst` mid-period with a divisor pending → all outputs reset in the same cycle. After release, the divisor is 4 again and the startup takes 18 edges again. `tick_cnt` preloaded near 0xFFFFFFFF wraps to 0 on the next tick.
